// File: rtl/tournament_predictor_gshare.sv
// Tournament branch predictor: local + gshare components with a PC-indexed meta chooser.
// Combinational prediction at fetch; training and GHR repair use snapshots carried from fetch.
module tournament_predictor_gshare #(
    parameter int PC_IDX_LSB  = 2,
    parameter int LOCAL_IDX_W = 4,
    parameter int META_IDX_W  = 4,
    parameter int GHR_W       = 4,
    parameter int CTR_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic             pred_local,
    output logic             pred_global,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_local,
    input  logic             upd_global,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic [31:0]      stat_preds,
    output logic [31:0]      stat_mispreds
);

    localparam int LOCAL_DEPTH = 1 << LOCAL_IDX_W;
    localparam int META_DEPTH  = 1 << META_IDX_W;
    localparam int GSHARE_DEPTH = 1 << GHR_W;

    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};

    logic [CTR_W-1:0] local_tbl  [LOCAL_DEPTH];
    logic [CTR_W-1:0] gshare_tbl [GSHARE_DEPTH];
    logic [CTR_W-1:0] meta_tbl   [META_DEPTH];
    logic [GHR_W-1:0] ghr;

    logic [LOCAL_IDX_W-1:0] p_lidx, u_lidx;
    logic [META_IDX_W-1:0]  p_midx, u_midx;
    logic [GHR_W-1:0]       p_gidx, u_gidx;
    logic                   p_meta;

    // Only the index slices of the PCs are meaningful; the rest is intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr, input logic up);
        if (up)
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
        else
            return (ctr == CTR_MIN) ? ctr : ctr - CTR_ONE;
    endfunction

    always_comb begin
        p_lidx = pred_pc[PC_IDX_LSB +: LOCAL_IDX_W];
        p_midx = pred_pc[PC_IDX_LSB +: META_IDX_W];
        p_gidx = pred_pc[PC_IDX_LSB +: GHR_W] ^ ghr;
        u_lidx = upd_pc[PC_IDX_LSB +: LOCAL_IDX_W];
        u_midx = upd_pc[PC_IDX_LSB +: META_IDX_W];
        u_gidx = upd_pc[PC_IDX_LSB +: GHR_W] ^ upd_ghr;
    end

    // Reads see pre-edge table contents, so a same-cycle train never bypasses into the prediction.
    always_comb begin
        pred_local  = local_tbl[p_lidx][CTR_W-1];
        pred_global = gshare_tbl[p_gidx][CTR_W-1];
        p_meta      = meta_tbl[p_midx][CTR_W-1];
        pred_taken  = p_meta ? pred_global : pred_local;
        pred_ghr    = ghr;
    end

    // NOTE: tables are flop arrays (not RAM) precisely so a single synchronous reset cycle can
    // reinitialise every entry; a RAM-based table would need a multi-cycle clear sequence.
    // NOTE: all state below uses non-blocking assignments so every read in this block and in the
    // combinational prediction path sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOCAL_DEPTH; i++)  local_tbl[i]  <= CTR_INIT;
            for (int i = 0; i < GSHARE_DEPTH; i++) gshare_tbl[i] <= CTR_INIT;
            for (int i = 0; i < META_DEPTH; i++)   meta_tbl[i]   <= CTR_INIT;
            ghr           <= '0;
            stat_preds    <= '0;
            stat_mispreds <= '0;
        end else begin
            if (upd_valid) begin
                local_tbl[u_lidx]  <= ctr_step(local_tbl[u_lidx], upd_taken);
                gshare_tbl[u_gidx] <= ctr_step(gshare_tbl[u_gidx], upd_taken);
                // The chooser only learns when the components disagreed.
                if (upd_local != upd_global)
                    meta_tbl[u_midx] <= ctr_step(meta_tbl[u_midx], upd_global == upd_taken);
            end

            if (upd_valid && upd_mispredict)
                ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
            else if (pred_valid)
                ghr <= {ghr[GHR_W-2:0], pred_taken};

            if (pred_valid && stat_preds != 32'hFFFF_FFFF)
                stat_preds <= stat_preds + 32'd1;
            if (upd_valid && upd_mispredict && stat_mispreds != 32'hFFFF_FFFF)
                stat_mispreds <= stat_mispreds + 32'd1;
        end
    end

endmodule

// File: tb/tb_tournament_predictor_gshare.sv
// Directed self-checking bench for tournament_predictor_gshare (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_tournament_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken, pred_local, pred_global;
    logic [3:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_local, upd_global, upd_taken, upd_mispredict;
    logic [31:0] stat_preds, stat_mispreds;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    tournament_predictor_gshare dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_local     (pred_local),
        .pred_global    (pred_global),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_local      (upd_local),
        .upd_global     (upd_global),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .stat_preds     (stat_preds),
        .stat_mispreds  (stat_mispreds)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid = 1'b0; pred_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_ghr = 4'h0;
        upd_local = 1'b0; upd_global = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [3:0] g, input logic loc,
                         input logic glb, input logic tk);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g;
        upd_local = loc; upd_global = glb; upd_taken = tk; upd_mispredict = 1'b0;
        step();
        upd_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        pred_pc = 32'h40;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fails++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_local !== 1'b0) begin n_fails++; $display("FAIL reset_local: got %b want 0", pred_local); end
        n_checks++; if (pred_global !== 1'b0) begin n_fails++; $display("FAIL reset_global: got %b want 0", pred_global); end
        n_checks++; if (pred_ghr !== 4'h0) begin n_fails++; $display("FAIL reset_ghr: got %h want 0", pred_ghr); end
        n_checks++; if (stat_preds !== 32'd0) begin n_fails++; $display("FAIL reset_preds: got %0d want 0", stat_preds); end
        n_checks++; if (stat_mispreds !== 32'd0) begin n_fails++; $display("FAIL reset_mispreds: got %0d want 0", stat_mispreds); end
    endtask

    // local[0] and gshare[0] go 01 -> 10 -> 11, then two not-taken bring them back to 01.
    task automatic test_local_training();
        logic exp_after [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic tk_seq    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            train(32'h40, 4'h0, 1'b0, 1'b0, tk_seq[i]);
            pred_pc = 32'h40;
            #1;
            n_checks++; if (pred_local !== exp_after[i]) begin n_fails++; $display("FAIL local_train_%0d: got %b want %b", i, pred_local, exp_after[i]); end
            n_checks++; if (pred_taken !== exp_after[i]) begin n_fails++; $display("FAIL local_taken_%0d: got %b want %b", i, pred_taken, exp_after[i]); end
        end
    endtask

    // Train gshare at index 1^2=3 so that at fetch (ghr=0, gidx=1) global disagrees with local.
    task automatic test_meta_training();
        for (int i = 0; i < 2; i++) begin
            train(32'h44, 4'h2, 1'b0, 1'b1, 1'b1);
            pred_pc = 32'h44;
            #1;
            n_checks++; if (pred_local !== 1'b1) begin n_fails++; $display("FAIL meta_local_%0d: got %b want 1", i, pred_local); end
            n_checks++; if (pred_global !== 1'b0) begin n_fails++; $display("FAIL meta_global_%0d: got %b want 0", i, pred_global); end
            n_checks++; if (pred_taken !== 1'b0) begin n_fails++; $display("FAIL meta_select_%0d: got %b want 0 (global)", i, pred_taken); end
        end
    endtask

    task automatic test_saturation();
        logic exp_nt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            train(32'h48, 4'h0, 1'b0, 1'b0, 1'b1);
            pred_pc = 32'h48;
            #1;
            n_checks++; if (pred_local !== 1'b1) begin n_fails++; $display("FAIL sat_hi_%0d: got %b want 1", i, pred_local); end
        end
        for (int i = 0; i < 5; i++) begin
            train(32'h48, 4'h0, 1'b0, 1'b0, 1'b0);
            pred_pc = 32'h48;
            #1;
            n_checks++; if (pred_local !== exp_nt[i]) begin n_fails++; $display("FAIL sat_lo_%0d: got %b want %b", i, pred_local, exp_nt[i]); end
            n_checks++; if (pred_taken !== exp_nt[i]) begin n_fails++; $display("FAIL sat_taken_%0d: got %b want %b", i, pred_taken, exp_nt[i]); end
        end
        // From 00, one taken gives 01 (still not-taken); a wrap to 11 would have shown earlier.
        train(32'h48, 4'h0, 1'b0, 1'b0, 1'b1);
        #1;
        n_checks++; if (pred_local !== 1'b0) begin n_fails++; $display("FAIL sat_floor: got %b want 0", pred_local); end
    endtask

    task automatic test_ghr_repair();
        do_reset();
        pred_pc = 32'h40;
        pred_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (pred_taken !== 1'b0) begin n_fails++; $display("FAIL spec_taken_%0d: got %b want 0", i, pred_taken); end
            step();
            n_checks++; if (pred_ghr !== 4'h0) begin n_fails++; $display("FAIL spec_ghr_%0d: got %h want 0", i, pred_ghr); end
        end
        upd_valid = 1'b1; upd_pc = 32'h4C; upd_ghr = 4'b0101; upd_taken = 1'b1;
        upd_local = 1'b0; upd_global = 1'b0; upd_mispredict = 1'b1;
        step();
        idle_inputs();
        #1;
        n_checks++; if (pred_ghr !== 4'b1011) begin n_fails++; $display("FAIL repair_ghr: got %b want 1011", pred_ghr); end
        n_checks++; if (stat_mispreds !== 32'd1) begin n_fails++; $display("FAIL repair_mispreds: got %0d want 1", stat_mispreds); end
        n_checks++; if (stat_preds !== 32'd4) begin n_fails++; $display("FAIL repair_preds: got %0d want 4", stat_preds); end
        // Plain speculation after repair shifts in the (not-taken) prediction.
        pred_valid = 1'b1; pred_pc = 32'h40;
        step();
        pred_valid = 1'b0;
        #1;
        n_checks++; if (pred_ghr !== 4'b0110) begin n_fails++; $display("FAIL spec_shift: got %b want 0110", pred_ghr); end
        n_checks++; if (stat_preds !== 32'd5) begin n_fails++; $display("FAIL spec_preds: got %0d want 5", stat_preds); end
    endtask

    task automatic test_same_cycle();
        pred_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_ghr = 4'h0; upd_taken = 1'b1;
        upd_local = 1'b0; upd_global = 1'b0; upd_mispredict = 1'b0;
        #1;
        n_checks++; if (pred_local !== 1'b0) begin n_fails++; $display("FAIL conflict_old: got %b want 0", pred_local); end
        step();
        upd_valid = 1'b0;
        #1;
        n_checks++; if (pred_local !== 1'b1) begin n_fails++; $display("FAIL conflict_new: got %b want 1", pred_local); end
    endtask

    // local[0] is 10 here; a reset cycle carrying a taken update must leave it at 01.
    task automatic test_reset_discard();
        pred_valid = 1'b1; pred_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 4'hF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        pred_pc = 32'h40;
        #1;
        n_checks++; if (pred_local !== 1'b0) begin n_fails++; $display("FAIL discard_local: got %b want 0", pred_local); end
        n_checks++; if (pred_ghr !== 4'h0) begin n_fails++; $display("FAIL discard_ghr: got %h want 0", pred_ghr); end
        n_checks++; if (stat_preds !== 32'd0) begin n_fails++; $display("FAIL discard_preds: got %0d want 0", stat_preds); end
        n_checks++; if (stat_mispreds !== 32'd0) begin n_fails++; $display("FAIL discard_mispreds: got %0d want 0", stat_mispreds); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_local_training();
        test_meta_training();
        test_saturation();
        test_ghr_repair();
        test_same_cycle();
        test_reset_discard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tournament_predictor_gshare.md
Name: tournament_predictor_gshare

Overview:
Parametrised second-generation tournament branch predictor for the fetch stage. It contains three tables of saturating counters:
- a PC-indexed local pattern table;
- a gshare global table indexed by PC XOR a speculative global history register (GHR);
- a PC-indexed meta (chooser) table, replacing the single shared chooser.
Prediction is combinational at fetch. Training uses the PC and history snapshot carried down the pipeline, so fetch and resolve can run on different branches in the same cycle. The GHR is repaired on mispredict.

Parameters:
PC_IDX_LSB, 2, lowest PC bit used for all table indexing
LOCAL_IDX_W, 4, local table has 2^LOCAL_IDX_W counters
META_IDX_W, 4, meta table has 2^META_IDX_W counters
GHR_W, 4, GHR width; gshare table has 2^GHR_W counters
CTR_W, 2, width of every saturating counter (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pred_valid  in  1  fetch is requesting a prediction this cycle
pred_pc  in  32  fetch PC
pred_taken  out  1  final prediction
pred_local  out  1  local component prediction
pred_global  out  1  gshare component prediction
pred_ghr  out  GHR_W  GHR value used for this prediction (pre-shift snapshot)
upd_valid  in  1  resolved branch training strobe
upd_pc  in  32  PC of resolved branch
upd_ghr  in  GHR_W  pred_ghr snapshot carried with the branch
upd_local  in  1  pred_local snapshot
upd_global  in  1  pred_global snapshot
upd_taken  in  1  actual outcome
upd_mispredict  in  1  final prediction was wrong
stat_preds  out  32  count of pred_valid cycles
stat_mispreds  out  32  count of upd_valid && upd_mispredict cycles

Behaviour:
- Indices:
  - lidx = pc[PC_IDX_LSB +: LOCAL_IDX_W]
  - midx = pc[PC_IDX_LSB +: META_IDX_W]
  - gidx = pc[PC_IDX_LSB +: GHR_W] ^ ghr
  - Fetch uses pred_pc and the live GHR. Update uses upd_pc and upd_ghr.
- Component predictions: pred_local and pred_global are the MSB of the addressed counter.
- Chooser: meta counter MSB=1 selects global, 0 selects local.
- Output timing: pred_taken, pred_local, pred_global and pred_ghr are purely combinational. They are driven every cycle regardless of pred_valid, from state before any same-edge write.
- Reset:
  - Every local, gshare and meta counter is set to 2^(CTR_W-1)-1 (weak not-taken / weak local). For CTR_W=2 this is 2'b01.
  - ghr=0, stat counters=0.
  - Tables are flop arrays so one reset cycle fully reinitialises them.
  - Reset asserted mid-operation discards pending writes that cycle.
  - With pred_ghr=0 and all counters at reset value, the outputs after reset are pred_taken=0, pred_local=0, pred_global=0.
- Training on upd_valid, at the clock edge:
  - The local counter[lidx(upd_pc)] increments if upd_taken, otherwise decrements.
  - The gshare counter[upd_pc bits ^ upd_ghr] is trained the same way.
  - Saturation: counters saturate at 0 and 2^CTR_W-1; no wrap.
- Meta training on upd_valid, only if upd_local != upd_global:
  - increment if upd_global==upd_taken;
  - otherwise decrement;
  - saturating.
  - If the components agree, meta is unchanged.
- GHR update, priority order:
  1. upd_valid && upd_mispredict: ghr <= {upd_ghr[GHR_W-2:0], upd_taken}. This is a repair and overrides same-cycle speculation.
  2. Else pred_valid: ghr <= {ghr[GHR_W-2:0], pred_taken}.
  3. Else hold.
- Same entry predicted and trained in one cycle: the prediction uses the old counter value; the write lands at the edge. No bypass.
- upd_valid with an arbitrary upd_ghr is legal. The gshare index uses upd_ghr, never the live GHR.
- stat counters: increment on the stated conditions and saturate at 0xFFFF_FFFF.

Test Plan:
1. Reset: assert rst 1 cycle, then pred_pc=0x40 → pred_taken=0, pred_local=0, pred_global=0, pred_ghr=0, stat_preds=0, stat_mispreds=0.
2. Local training: two updates with upd_pc=0x40, upd_taken=1, upd_local=0, upd_global=0, upd_ghr=0.
   - After the 1st: pred_pc=0x40 gives pred_local=1, pred_taken=1 (meta still 01, local selected).
   - After the 2nd: counter=11.
   - Meta is unchanged throughout.
3. Meta training: two updates with upd_pc=0x44, upd_local=0, upd_global=1, upd_taken=1 → meta[1] goes 01→10→11. A fresh pred_pc=0x44 then selects global: pred_taken=pred_global.
4. Saturation: five taken updates on pc 0x48 → local counter 11. Then five not-taken → 00. pred_local=0 after the 2nd not-taken and stays 0.
5. GHR speculate and repair:
   - From reset, 3 cycles of pred_valid with pred_taken=0 → ghr=0000.
   - Then one cycle with pred_valid=1 plus upd_valid=1, upd_mispredict=1, upd_ghr=0101, upd_taken=1 → ghr=1011 next cycle; stat_mispreds=1, stat_preds=4.
6. Same-cycle conflict:
   - Setup: pc 0x40 local counter at 01.
   - One cycle with pred_pc=0x40 plus upd_pc=0x40, upd_taken=1: pred_local=0 that cycle, pred_local=1 the following cycle.
